// File: rtl/video_chk_pkg.sv
// Shared types and helpers for the video pattern checker.
package video_chk_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_VS, CHECK} chk_state_t;

  localparam int               CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/video_pattern_checker_edge_generator.sv
// Input register plus one-cycle delay for edge detection; lvl is the registered input.
module edge_generator #(
  parameter MODE = "NORMAL"
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic lvl,
  output logic rise,
  output logic fall
);

  localparam bit INV = (MODE == "INVERT");

  logic s0, s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= sig ^ INV;
      s1 <= s0;
    end
  end

  assign lvl  = s0;
  assign rise = s0 & ~s1;
  assign fall = ~s0 & s1;

endmodule

// File: rtl/video_pattern_checker.sv
// Checks pixel ramp and line/frame geometry of the native video stream, reports lock.
// Optional first-error capture ports: define VIDEO_CHK_ERR_CAPTURE_EN.
//   state   | meaning
//   IDLE    | checker disabled
//   WAIT_VS | enabled, discarding the partial frame until a vsync rise
//   CHECK   | checking every pixel, line and frame
module video_pattern_checker
  import video_chk_pkg::*;
#(
  parameter int DSIZE       = 24,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             pclk,
  input  logic             prst,
  input  logic             enable,
  input  logic             clear,
  input  logic             vsync,
  input  logic             hsync,
  input  logic             de,
  input  logic [DSIZE-1:0] data,
  input  logic [CNT_W-1:0] hactive,
  input  logic [CNT_W-1:0] vactive,
  output logic             locked,
  output logic             data_err,
  output logic             hact_err,
  output logic             vact_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] frame_cnt
`ifdef VIDEO_CHK_ERR_CAPTURE_EN
  ,
  output logic             err_valid,
  output logic [CNT_W-1:0] err_line,
  output logic [CNT_W-1:0] err_pixel,
  output logic [DSIZE-1:0] err_data
`endif
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  chk_state_t       state, state_nxt;
  logic             r_enable, r_clear;
  logic [DSIZE-1:0] r_data;
  logic [CNT_W-1:0] r_hact, r_vact;
  logic             vs_lvl, vs_rise, vs_fall_unused;
  logic             de_lvl, de_rise_unused, de_fall;
  logic             unused_hsync;
  logic [CNT_W-1:0] pix_cnt, line_cnt, line_seen;
  logic [3:0]       good_cnt, good_nxt;
  logic             frame_bad, in_check;
  logic             data_err_c, hact_err_c, vact_err_c, any_err;
  logic [1:0]       err_sum;

  assign unused_hsync = hsync;

  edge_generator #(.MODE("NORMAL")) u_vs_edge (
    .clk(pclk), .rst(prst), .sig(vsync),
    .lvl(vs_lvl), .rise(vs_rise), .fall(vs_fall_unused)
  );

  edge_generator #(.MODE("NORMAL")) u_de_edge (
    .clk(pclk), .rst(prst), .sig(de),
    .lvl(de_lvl), .rise(de_rise_unused), .fall(de_fall)
  );

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_enable <= 1'b0;
      r_clear  <= 1'b0;
      r_data   <= '0;
      r_hact   <= '0;
      r_vact   <= '0;
    end else begin
      r_enable <= enable;
      r_clear  <= clear;
      r_data   <= data;
      r_hact   <= hactive;
      r_vact   <= vactive;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = WAIT_VS;
      WAIT_VS: if (vs_rise) state_nxt = CHECK;
      CHECK:   state_nxt = CHECK;
      default: state_nxt = IDLE;
    endcase
    if (!r_enable) state_nxt = IDLE;
  end

  // A line ending on the vsync-rise cycle still counts toward the height compare.
  always_comb begin
    in_check   = (state == CHECK);
    line_seen  = de_fall ? sat_add(line_cnt, 2'd1) : line_cnt;
    data_err_c = in_check && de_lvl && (r_data != DSIZE'(pix_cnt));
    hact_err_c = in_check && de_fall && (pix_cnt != r_hact);
    vact_err_c = in_check && vs_rise && (line_seen != r_vact);
    any_err    = data_err_c | hact_err_c | vact_err_c;
    err_sum    = 2'(data_err_c) + 2'(hact_err_c) + 2'(vact_err_c);
    good_nxt   = good_cnt;
    if (!in_check || state_nxt != CHECK || any_err)
      good_nxt = '0;
    else if (vs_rise && !frame_bad && good_cnt != LOCK_N)
      good_nxt = good_cnt + 4'd1;
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state     <= IDLE;
      pix_cnt   <= '0;
      line_cnt  <= '0;
      frame_cnt <= '0;
      err_cnt   <= '0;
      good_cnt  <= '0;
      frame_bad <= 1'b0;
      locked    <= 1'b0;
      data_err  <= 1'b0;
      hact_err  <= 1'b0;
      vact_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pix_cnt  <= de_lvl ? pix_cnt + CNT_W'(1) : '0;
      if (vs_rise)
        line_cnt <= '0;
      else if (de_fall)
        line_cnt <= line_seen;
      if (in_check && vs_rise)
        frame_cnt <= frame_cnt + CNT_W'(1);
      err_cnt   <= r_clear ? '0 : sat_add(err_cnt, err_sum);
      good_cnt  <= good_nxt;
      locked    <= (good_nxt == LOCK_N);
      frame_bad <= in_check && !vs_rise && (frame_bad || any_err);
      data_err  <= data_err_c;
      hact_err  <= hact_err_c;
      vact_err  <= vact_err_c;
    end
  end

`ifdef VIDEO_CHK_ERR_CAPTURE_EN
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      err_valid <= 1'b0;
      err_line  <= '0;
      err_pixel <= '0;
      err_data  <= '0;
    end else if (r_clear) begin
      err_valid <= 1'b0;
    end else if (data_err_c && !err_valid) begin
      err_valid <= 1'b1;
      err_line  <= line_cnt;
      err_pixel <= pix_cnt;
      err_data  <= r_data;
    end
  end
`endif

endmodule

// File: tb/tb_video_pattern_checker.sv
// Scoreboard bench for video_pattern_checker: directed frames with hand-placed faults,
// error pulses checked by a separate monitor two cycles after the offending input.
module tb_video_pattern_checker;

  localparam int H = 104;
  localparam int V = 6;

  logic        pclk = 1'b0;
  logic        prst, enable, clear, vsync, hsync, de;
  logic [23:0] data;
  logic [15:0] hactive, vactive;
  logic        locked, data_err, hact_err, vact_err;
  logic [15:0] err_cnt, frame_cnt;
`ifdef VIDEO_CHK_ERR_CAPTURE_EN
  logic        err_valid;
  logic [15:0] err_line, err_pixel;
  logic [23:0] err_data;
`endif

  typedef struct {
    int         c;
    logic [2:0] m;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   lines = 0;
  bit   chk_on = 1'b0;
  bit   mon_on = 1'b1;
  bit   clr_at_bad = 1'b0;

  video_pattern_checker #(.DSIZE(24), .LOCK_FRAMES(2)) dut (
    .pclk(pclk), .prst(prst), .enable(enable), .clear(clear),
    .vsync(vsync), .hsync(hsync), .de(de), .data(data),
    .hactive(hactive), .vactive(vactive),
    .locked(locked), .data_err(data_err), .hact_err(hact_err), .vact_err(vact_err),
    .err_cnt(err_cnt), .frame_cnt(frame_cnt)
`ifdef VIDEO_CHK_ERR_CAPTURE_EN
    , .err_valid(err_valid), .err_line(err_line), .err_pixel(err_pixel), .err_data(err_data)
`endif
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge pclk);
  endtask

  // mask bits: {vact, hact, data}; pulse is due two cycles after the driven cycle
  task automatic expect_err(input logic [2:0] m);
    exp_t e;
    if (sbq.size() > 0 && sbq[sbq.size()-1].c == cyc + 2) begin
      e = sbq.pop_back();
      e.m = e.m | m;
      sbq.push_back(e);
    end else begin
      e.c = cyc + 2;
      e.m = m;
      sbq.push_back(e);
    end
  endtask

  always @(negedge pclk) begin : monitor
    logic [2:0] got;
    exp_t       e;
    got = {vact_err, hact_err, data_err};
    if (mon_on) begin
      while (sbq.size() > 0 && sbq[0].c < cyc) begin
        e = sbq.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL err_missed: got no pulse, expected mask %b at cycle %0d", e.m, e.c);
      end
      if (sbq.size() > 0 && sbq[0].c == cyc) begin
        e = sbq.pop_front();
        chk("err_pulse", 32'(got), 32'(e.m));
      end else if (got != 3'b000) begin
        chk("err_unexpected", 32'(got), 32'd0);
      end
    end
  end

  task automatic vs_pulse();
    vsync = 1'b1;
    if (chk_on) begin
      if (lines != V) expect_err(3'b100);
    end else begin
      chk_on = 1'b1;
    end
    lines = 0;
    repeat (2) tick();
    vsync = 1'b0;
    repeat (2) tick();
  endtask

  task automatic line(input int npix, input int bad_pix, input logic [23:0] bad_val);
    hsync = 1'b1;
    tick();
    hsync = 1'b0;
    for (int p = 0; p < npix; p++) begin
      de    = 1'b1;
      data  = (p == bad_pix) ? bad_val : 24'(p);
      clear = clr_at_bad && (p == bad_pix);
      if (chk_on && p == bad_pix) expect_err(3'b001);
      tick();
    end
    de    = 1'b0;
    data  = '0;
    clear = 1'b0;
    if (chk_on && npix != H) expect_err(3'b010);
    lines++;
    repeat (2) tick();
  endtask

  task automatic body(input int nl, input int short_ln, input int bad_ln,
                      input int bad_pix, input logic [23:0] bad_val);
    for (int l = 0; l < nl; l++)
      line((l == short_ln) ? H - 1 : H, (l == bad_ln) ? bad_pix : -1, bad_val);
  endtask

  initial begin : watchdog
    repeat (95000) @(posedge pclk);
    n_bad++;
    $display("FAIL watchdog: got no finish, expected finish within 95000 cycles");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    prst = 1'b1; enable = 1'b1; clear = 1'b0;
    vsync = 1'b0; hsync = 1'b0; de = 1'b0; data = '0;
    hactive = 16'(H); vactive = 16'(V);
    repeat (3) tick();
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    prst = 1'b0;
    repeat (2) tick();

    // clean stream: the leading partial frame carries a bad pixel that must be ignored
    body(3, -1, 1, 5, 24'h77);
    vs_pulse();
    body(V, -1, -1, -1, '0);
    vs_pulse();
    chk("t1_frame_cnt1", 32'(frame_cnt), 1);
    chk("t1_unlocked", 32'(locked), 0);
    body(V, -1, -1, -1, '0);
    vs_pulse();
    chk("t1_frame_cnt2", 32'(frame_cnt), 2);
    chk("t1_locked", 32'(locked), 1);
    chk("t1_err_cnt", 32'(err_cnt), 0);

    // corrupt pixel 100 of line index 4
    body(V, -1, 4, 100, 24'd7);
    chk("t2_err_cnt", 32'(err_cnt), 1);
    chk("t2_lost_lock", 32'(locked), 0);
`ifdef VIDEO_CHK_ERR_CAPTURE_EN
    chk("t2_err_valid", 32'(err_valid), 1);
    chk("t2_err_line", 32'(err_line), 4);
    chk("t2_err_pixel", 32'(err_pixel), 100);
    chk("t2_err_data", 32'(err_data), 7);
`endif
    vs_pulse();
    body(V, -1, -1, -1, '0);
    vs_pulse();
    chk("t2_one_good", 32'(locked), 0);
    body(V, -1, -1, -1, '0);
    vs_pulse();
    chk("t2_relocked", 32'(locked), 1);
    chk("t2_frame_cnt", 32'(frame_cnt), 5);

    // one short line
    body(V, 2, -1, -1, '0);
    chk("t3_err_cnt", 32'(err_cnt), 2);
    chk("t3_lost_lock", 32'(locked), 0);
    vs_pulse();

    // one line missing from the frame
    body(V - 1, -1, -1, -1, '0);
    vs_pulse();
    chk("t4_frame_cnt", 32'(frame_cnt), 7);
    chk("t4_err_cnt", 32'(err_cnt), 3);

    // clear lands on the same cycle as an error
    clr_at_bad = 1'b1;
    body(V, -1, 2, 50, 24'h3);
    clr_at_bad = 1'b0;
    chk("t5_clear_wins", 32'(err_cnt), 0);
`ifdef VIDEO_CHK_ERR_CAPTURE_EN
    chk("t5_capture_cleared", 32'(err_valid), 0);
`endif
    vs_pulse();
    chk("t5_frame_cnt", 32'(frame_cnt), 8);
    chk("t5_err_cnt_after", 32'(err_cnt), 0);
    chk("t5_sbq_drained", sbq.size(), 0);

    // reset in the middle of a line
    hsync = 1'b1;
    tick();
    hsync = 1'b0;
    for (int p = 0; p < 10; p++) begin
      de = 1'b1;
      data = 24'(p);
      tick();
    end
    prst = 1'b1;
    chk_on = 1'b0;
    lines = 0;
    repeat (2) tick();
    chk("prst_frame_cnt", 32'(frame_cnt), 0);
    chk("prst_locked", 32'(locked), 0);
    chk("prst_err_cnt", 32'(err_cnt), 0);
    prst = 1'b0;
    for (int p = 10; p < H; p++) begin
      de = 1'b1;
      data = 24'h5A;
      tick();
    end
    de = 1'b0;
    data = '0;
    repeat (2) tick();
    body(V - 1, -1, 0, 3, 24'h99);
    vs_pulse();
    body(V, -1, -1, -1, '0);
    vs_pulse();
    chk("t5_resume_frame_cnt", 32'(frame_cnt), 1);
    chk("t5_resume_err_cnt", 32'(err_cnt), 0);
    chk("t5_sbq_final", sbq.size(), 0);

    // 70000 consecutive bad pixels saturate the error counter
    mon_on = 1'b0;
    de = 1'b1;
    data = 24'hFFFFFF;
    repeat (70000) tick();
    de = 1'b0;
    data = '0;
    repeat (4) tick();
    chk("t6_err_cnt_sat", 32'(err_cnt), 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
